// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, issues single-outstanding word reads to instruction memory
// and holds one fetched instruction for decode, squashing fetches made stale by redirects.
module instruction_fetch_unit #(
    parameter int              AW       = 16,
    parameter int              IW       = 32,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,

    output logic          imem_req,
    output logic [AW-1:0] imem_addr,
    input  logic          imem_valid,
    input  logic [IW-1:0] imem_rdata,

    input  logic          stall,
    input  logic [1:0]    JMPSel,
    input  logic [AW-1:0] jmp_target,
    input  logic [AW-1:0] jr_target,
    input  logic          branch_taken,
    input  logic [AW-1:0] branch_target,

    output logic          if_valid,
    output logic [IW-1:0] if_instr,
    output logic [AW-1:0] if_pc,
    output logic [4:0]    OPcode,
    output logic [2:0]    ALUop,

    output logic          dbg_fsm_state
);

    // Handshake: imem_req is a one-cycle pulse carrying imem_addr; exactly one
    // imem_valid pulse answers it at least one cycle later. Decode accepts the
    // held instruction in any cycle with if_valid=1 and stall=0.

    typedef enum logic {
        S_REQ  = 1'b0,
        S_WAIT = 1'b1
    } fetch_state_e;

    fetch_state_e  state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic          squash_q, squash_d;
    logic          if_valid_q, if_valid_d;
    logic [IW-1:0] if_instr_q, if_instr_d;
    logic [AW-1:0] if_pc_q, if_pc_d;

    logic          consume;
    logic          dec_redirect;
    logic          redirect;
    logic [AW-1:0] redirect_target;
    logic          issue;

    always_comb begin
        consume      = if_valid_q && !stall;
        dec_redirect = consume && (JMPSel == 2'b01 || JMPSel == 2'b10);
        redirect     = branch_taken || dec_redirect;

        if (branch_taken) begin
            redirect_target = branch_target;
        end else if (JMPSel == 2'b01) begin
            redirect_target = jmp_target;
        end else begin
            redirect_target = jr_target;
        end

        // A request is only made when the output register will be free by the response.
        issue = (state_q == S_REQ) && (!if_valid_q || !stall) && !redirect && !rst;
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        squash_d   = squash_q;
        if_valid_d = if_valid_q && !consume;
        if_instr_d = if_instr_q;
        if_pc_d    = if_pc_q;

        case (state_q)
            S_REQ: begin
                if (issue) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (imem_valid) begin
                    state_d  = S_REQ;
                    squash_d = 1'b0;
                    if (!squash_q && !redirect) begin
                        if_valid_d = 1'b1;
                        if_instr_d = imem_rdata;
                        if_pc_d    = pc_q;
                        pc_d       = pc_q + {{(AW-1){1'b0}}, 1'b1};
                    end
                end else if (redirect) begin
                    // The in-flight response belongs to the old path.
                    squash_d = 1'b1;
                end
            end
            default: begin
                state_d = S_REQ;
            end
        endcase

        if (redirect) begin
            pc_d       = redirect_target;
            if_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_REQ;
            pc_q       <= RESET_PC;
            squash_q   <= 1'b0;
            if_valid_q <= 1'b0;
            if_instr_q <= '0;
            if_pc_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            squash_q   <= squash_d;
            if_valid_q <= if_valid_d;
            if_instr_q <= if_instr_d;
            if_pc_q    <= if_pc_d;
        end
    end

    assign imem_req      = issue;
    assign imem_addr     = pc_q;
    assign if_valid      = if_valid_q;
    assign if_instr      = if_instr_q;
    assign if_pc         = if_pc_q;
    assign OPcode        = if_instr_q[IW-1 -: 5];
    assign ALUop         = if_instr_q[IW-6 -: 3];
    assign dbg_fsm_state = state_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: sequential fetch, stall, JMP, branch priority,
// squash, same-cycle redirect, async reset and PC wrap, with a latency-programmable memory.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rst_w = 1'b1;

    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic [1:0]  jmp_sel = 2'b00;
    logic [15:0] jmp_target = '0;
    logic [15:0] jr_target = '0;
    logic        branch_taken = 1'b0;
    logic [15:0] branch_target = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [15:0] if_pc;
    logic [4:0]  opcode;
    logic [2:0]  aluop;
    logic        dbg_state;

    logic        w_req;
    logic [15:0] w_addr;
    logic        w_valid = 1'b0;
    logic [31:0] w_rdata = '0;
    logic        w_if_valid;
    logic [31:0] w_if_instr;
    logic [15:0] w_if_pc;
    logic [4:0]  w_opcode;
    logic [2:0]  w_aluop;
    logic        w_dbg;
    logic        w_stall = 1'b0;
    logic [1:0]  w_jmp_sel = 2'b00;
    logic        w_branch = 1'b0;
    logic [15:0] w_zero = '0;

    int checks = 0;
    int failures = 0;
    int lat = 1;

    logic [31:0] exp_q[$];

    instruction_fetch_unit #(.AW(16), .IW(32), .RESET_PC(16'h0000)) u_dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_valid(imem_valid), .imem_rdata(imem_rdata),
        .stall(stall), .JMPSel(jmp_sel), .jmp_target(jmp_target), .jr_target(jr_target),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
        .OPcode(opcode), .ALUop(aluop), .dbg_fsm_state(dbg_state)
    );

    instruction_fetch_unit #(.AW(16), .IW(32), .RESET_PC(16'hFFFF)) u_wrap (
        .clk(clk), .rst(rst_w),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_valid(w_valid), .imem_rdata(w_rdata),
        .stall(w_stall), .JMPSel(w_jmp_sel), .jmp_target(w_zero), .jr_target(w_zero),
        .branch_taken(w_branch), .branch_target(w_zero),
        .if_valid(w_if_valid), .if_instr(w_if_instr), .if_pc(w_if_pc),
        .OPcode(w_opcode), .ALUop(w_aluop), .dbg_fsm_state(w_dbg)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        case (a)
            16'h0000: return 32'h0000_0001;
            16'h0001: return 32'h4000_0002;
            16'h0002: return 32'h8000_0003;
            default:  return {16'h2B00, a};
        endcase
    endfunction

    // Memory models act on the falling edge so responses never race the DUT's rising edge.
    logic        pend = 1'b0;
    logic [15:0] pend_addr = '0;
    int          cnt = 0;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            pend = 1'b0;
            cnt = 0;
            imem_valid = 1'b0;
        end else begin
            imem_valid = 1'b0;
            if (pend) begin
                cnt = cnt - 1;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = mem_word(pend_addr);
                    pend = 1'b0;
                end
            end
            if (imem_req) begin
                pend = 1'b1;
                pend_addr = imem_addr;
                cnt = lat;
            end
        end
    end

    logic        w_pend = 1'b0;
    logic [15:0] w_pend_addr = '0;
    always @(negedge clk or posedge rst_w) begin
        if (rst_w) begin
            w_pend = 1'b0;
            w_valid = 1'b0;
        end else begin
            w_valid = 1'b0;
            if (w_pend) begin
                w_valid = 1'b1;
                w_rdata = mem_word(w_pend_addr);
                w_pend = 1'b0;
            end
            if (w_req) begin
                w_pend = 1'b1;
                w_pend_addr = w_addr;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%0b exp=0", imem_req); end
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", if_valid); end
        checks++; if (if_instr !== 32'h0) begin failures++; $display("FAIL reset_instr got=%h exp=0", if_instr); end
        checks++; if (if_pc !== 16'h0) begin failures++; $display("FAIL reset_pc got=%h exp=0", if_pc); end
        checks++; if (opcode !== 5'h0 || aluop !== 3'h0) begin failures++; $display("FAIL reset_fields got=%b/%b exp=0/0", opcode, aluop); end
        checks++; if (imem_addr !== 16'h0) begin failures++; $display("FAIL reset_addr got=%h exp=0", imem_addr); end
        checks++; if (dbg_state !== 1'b0) begin failures++; $display("FAIL reset_state got=%0b exp=0", dbg_state); end
    endtask

    task automatic test_sequential();
        logic [4:0]  exp_op;
        logic [31:0] exp_instr;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin failures++; $display("FAIL seq_first_req got=%0b@%h exp=1@0000", imem_req, imem_addr); end
        exp_q.push_back(32'h0000_0001);
        exp_q.push_back(32'h4000_0002);
        exp_q.push_back(32'h8000_0003);
        for (int k = 0; k < 3; k++) begin
            tick(); #1;
            checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL seq_wait%0d got req=%0b valid=%0b exp 0/0", k, imem_req, if_valid); end
            tick(); #1;
            exp_instr = exp_q.pop_front();
            exp_op = (k == 0) ? 5'b00000 : (k == 1) ? 5'b01000 : 5'b10000;
            checks++; if (if_valid !== 1'b1 || if_pc !== 16'(k)) begin failures++; $display("FAIL seq_out%0d got valid=%0b pc=%h exp 1/%h", k, if_valid, if_pc, k); end
            checks++; if (if_instr !== exp_instr) begin failures++; $display("FAIL seq_instr%0d got=%h exp=%h", k, if_instr, exp_instr); end
            checks++; if (opcode !== exp_op) begin failures++; $display("FAIL seq_opcode%0d got=%b exp=%b", k, opcode, exp_op); end
            checks++; if (imem_req !== 1'b1 || imem_addr !== 16'(k + 1)) begin failures++; $display("FAIL seq_req%0d got=%0b@%h exp=1@%h", k, imem_req, imem_addr, k + 1); end
        end
    endtask

    task automatic test_stall();
        tick(); #1;
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL stall_pre got req=%0b valid=%0b exp 0/0", imem_req, if_valid); end
        tick();
        stall = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin tick(); #1; end
            checks++; if (if_valid !== 1'b1 || if_pc !== 16'h3 || if_instr !== 32'h2B00_0003) begin failures++; $display("FAIL stall_hold%0d got %0b/%h/%h exp 1/0003/2b000003", i, if_valid, if_pc, if_instr); end
            checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL stall_noreq%0d got=%0b exp=0", i, imem_req); end
        end
        checks++; if (aluop !== 3'b011 || opcode !== 5'b00101) begin failures++; $display("FAIL stall_fields got=%b/%b exp=00101/011", opcode, aluop); end
        tick();
        stall = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h4) begin failures++; $display("FAIL stall_resume got=%0b@%h exp=1@0004", imem_req, imem_addr); end
    endtask

    task automatic test_jmp();
        tick(); #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL jmp_wait got=%0b exp=0", imem_req); end
        tick();
        jmp_sel = 2'b01;
        jmp_target = 16'h0040;
        #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h4) begin failures++; $display("FAIL jmp_src got %0b/%h exp 1/0004", if_valid, if_pc); end
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL jmp_noreq got=%0b exp=0", imem_req); end
        tick();
        jmp_sel = 2'b00;
        #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL jmp_cleared got=%0b exp=0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin failures++; $display("FAIL jmp_target_req got=%0b@%h exp=1@0040", imem_req, imem_addr); end
        tick(); #1;
        tick(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0040 || if_instr !== 32'h2B00_0040) begin failures++; $display("FAIL jmp_out got %0b/%h/%h exp 1/0040/2b000040", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_branch_priority();
        branch_taken = 1'b1;
        branch_target = 16'h0100;
        jmp_sel = 2'b10;
        jr_target = 16'h0200;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL prio_noreq got=%0b exp=0", imem_req); end
        tick();
        branch_taken = 1'b0;
        jmp_sel = 2'b00;
        #1;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0100) begin failures++; $display("FAIL prio_req got valid=%0b req=%0b@%h exp 0/1@0100", if_valid, imem_req, imem_addr); end
        tick(); #1;
        tick(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0100) begin failures++; $display("FAIL prio_out got %0b/%h exp 1/0100", if_valid, if_pc); end
    endtask

    task automatic test_squash();
        lat = 3;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0101) begin failures++; $display("FAIL sq_req got=%0b@%h exp=1@0101", imem_req, imem_addr); end
        tick();
        branch_taken = 1'b1;
        branch_target = 16'h0080;
        #1;
        checks++; if (imem_req !== 1'b0 || dbg_state !== 1'b1) begin failures++; $display("FAIL sq_branch got req=%0b st=%0b exp 0/1", imem_req, dbg_state); end
        tick();
        branch_taken = 1'b0;
        #1;
        tick(); #1;
        checks++; if (imem_req !== 1'b0 || dbg_state !== 1'b1) begin failures++; $display("FAIL sq_still_wait got req=%0b st=%0b exp 0/1", imem_req, dbg_state); end
        tick(); #1;
        checks++; if (if_valid !== 1'b0) begin failures++; $display("FAIL sq_discard got=%0b exp=0", if_valid); end
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin failures++; $display("FAIL sq_target_req got=%0b@%h exp=1@0080", imem_req, imem_addr); end
        for (int i = 0; i < 3; i++) begin
            tick(); #1;
            checks++; if (if_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL sq_latency%0d got valid=%0b req=%0b exp 0/0", i, if_valid, imem_req); end
        end
        tick(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0080 || if_instr !== 32'h2B00_0080) begin failures++; $display("FAIL sq_out got %0b/%h/%h exp 1/0080/2b000080", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_same_cycle_redirect();
        lat = 1;
        #1;
        tick();
        branch_taken = 1'b1;
        branch_target = 16'h0020;
        #1;
        checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL same_noreq got=%0b exp=0", imem_req); end
        tick();
        branch_taken = 1'b0;
        #1;
        checks++; if (if_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0020) begin failures++; $display("FAIL same_req got valid=%0b req=%0b@%h exp 0/1@0020", if_valid, imem_req, imem_addr); end
        tick(); #1;
        tick(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0020 || if_instr !== 32'h2B00_0020) begin failures++; $display("FAIL same_out got %0b/%h/%h exp 1/0020/2b000020", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_async_reset();
        tick(); #1;
        checks++; if (dbg_state !== 1'b1) begin failures++; $display("FAIL ar_in_wait got=%0b exp=1", dbg_state); end
        rst = 1'b1;
        #1;
        checks++; if (imem_req !== 1'b0 || if_valid !== 1'b0) begin failures++; $display("FAIL ar_immediate got req=%0b valid=%0b exp 0/0", imem_req, if_valid); end
        checks++; if (if_pc !== 16'h0 || if_instr !== 32'h0 || dbg_state !== 1'b0 || imem_addr !== 16'h0) begin failures++; $display("FAIL ar_state got pc=%h instr=%h st=%0b addr=%h exp 0/0/0/0", if_pc, if_instr, dbg_state, imem_addr); end
        tick();
        tick();
        rst = 1'b0;
        #1;
        checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0) begin failures++; $display("FAIL ar_first_req got=%0b@%h exp=1@0000", imem_req, imem_addr); end
        tick(); #1;
        tick(); #1;
        checks++; if (if_valid !== 1'b1 || if_pc !== 16'h0 || if_instr !== 32'h0000_0001) begin failures++; $display("FAIL ar_out got %0b/%h/%h exp 1/0000/00000001", if_valid, if_pc, if_instr); end
    endtask

    task automatic test_wrap();
        tick();
        rst_w = 1'b0;
        #1;
        checks++; if (w_req !== 1'b1 || w_addr !== 16'hFFFF) begin failures++; $display("FAIL wrap_first_req got=%0b@%h exp=1@ffff", w_req, w_addr); end
        tick(); #1;
        tick(); #1;
        checks++; if (w_if_valid !== 1'b1 || w_if_pc !== 16'hFFFF || w_if_instr !== 32'h2B00_FFFF) begin failures++; $display("FAIL wrap_out got %0b/%h/%h exp 1/ffff/2b00ffff", w_if_valid, w_if_pc, w_if_instr); end
        checks++; if (w_req !== 1'b1 || w_addr !== 16'h0000) begin failures++; $display("FAIL wrap_next_req got=%0b@%h exp=1@0000", w_req, w_addr); end
        tick(); #1;
        tick(); #1;
        checks++; if (w_if_valid !== 1'b1 || w_if_pc !== 16'h0000 || w_if_instr !== 32'h0000_0001) begin failures++; $display("FAIL wrap_out0 got %0b/%h/%h exp 1/0000/00000001", w_if_valid, w_if_pc, w_if_instr); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_jmp();
        test_branch_priority();
        test_squash();
        test_same_cycle_redirect();
        test_async_reset();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
